// File: rtl/pipeline_defs.sv
// Shared definitions for the PCIMID pipeline front end: default widths,
// bubble word and reset PC, plus the per-edge fetch action encoding.
package pipeline_defs;

  localparam int          DEF_ADDR_W   = 8;
  localparam int          DEF_DATA_W   = 32;
  localparam int          DEF_CNT_W    = 16;
  localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;
  localparam logic [7:0]  DEF_RESET_PC = 8'h00;

  // What the fetch stage does on a given clock edge (reset handled separately).
  typedef enum logic [2:0] {
    ACT_NORMAL  = 3'd0,  // advance PC, capture fetched word
    ACT_STALL   = 3'd1,  // hold PC and IF/ID
    ACT_FLUSH   = 3'd2,  // bubble IF/ID, advance PC
    ACT_FLUSH_H = 3'd3,  // bubble IF/ID, hold PC (flush under stall)
    ACT_BRANCH  = 3'd4   // redirect PC, bubble IF/ID
  } fetch_act_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: instruction, PC+1 and valid, with hold and bubble
// controls. Bubble wins over hold; reset wins over both.
module ifid_reg #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              bubble,
  input  logic [DATA_W-1:0] instr_p0,
  input  logic [ADDR_W-1:0] pcplus1_p0,
  output logic [DATA_W-1:0] instr_p1,
  output logic [ADDR_W-1:0] pcplus1_p1,
  output logic              vld_p1
);

  // Stage p0 -> p1: capture the fetched word, insert a bubble, or hold.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      instr_p1   <= NOP_WORD;
      pcplus1_p1 <= '0;
      vld_p1     <= 1'b0;
    end else if (!hold) begin
      instr_p1   <= instr_p0;
      pcplus1_p1 <= pcplus1_p0;
      vld_p1     <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register driving the combinational
// instruction memory, IF/ID register for decode, and a count of valid
// instructions delivered to IF/ID.
module fetch_stage
  import pipeline_defs::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEF_NOP_WORD),
  parameter int                CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic [DATA_W-1:0] InstructionIn,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] InstructionOut,
  output logic [ADDR_W-1:0] PCPlus1Out,
  output logic              ValidOut,
  output logic [CNT_W-1:0]  FetchCount
);

  logic [ADDR_W-1:0] pc_p0;
  logic [ADDR_W-1:0] pc_inc_p0;
  logic [CNT_W-1:0]  cnt;
  fetch_act_e        act;

  // PC+1 wraps naturally at 2^ADDR_W.
  assign pc_inc_p0 = pc_p0 + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Resolve the per-edge action: branch over flush over stall over normal.
  always_comb begin
    act = ACT_NORMAL;
    if (BranchTaken)      act = ACT_BRANCH;
    else if (Flush)       act = Stall ? ACT_FLUSH_H : ACT_FLUSH;
    else if (Stall)       act = ACT_STALL;
  end

  // Stage p0: program counter, registered so Address has no input path.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0 <= RESET_PC;
    end else begin
      case (act)
        ACT_BRANCH:              pc_p0 <= BranchTarget;
        ACT_STALL, ACT_FLUSH_H:  pc_p0 <= pc_p0;
        default:                 pc_p0 <= pc_inc_p0;
      endcase
    end
  end

  // Count only edges that load a real instruction into IF/ID.
  always_ff @(posedge clk) begin
    if (reset)                  cnt <= '0;
    else if (act == ACT_NORMAL) cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  ifid_reg #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NOP_WORD (NOP_WORD)
  ) u_ifid (
    .clk        (clk),
    .reset      (reset),
    .hold       (act == ACT_STALL),
    .bubble     (BranchTaken || Flush),
    .instr_p0   (InstructionIn),
    .pcplus1_p0 (pc_inc_p0),
    .instr_p1   (InstructionOut),
    .pcplus1_p1 (PCPlus1Out),
    .vld_p1     (ValidOut)
  );

  assign Address    = pc_p0;
  assign FetchCount = cnt;

endmodule
